// File: rtl/rv32i_types.sv
// Shared RV32I fetch constants and the fetch-queue entry type.
package rv32i_types;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0060;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fifo.sv
// Circular {pc, instr} buffer with a combinational head; writes are visible one cycle after push.
// Pushes when full and pops when empty are ignored; flush beats a same-cycle push or pop.
module inst_fifo
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers are PW bits wide, so wrap modulo DEPTH falls out of the arithmetic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/inst_queue.sv
// Instruction fetch queue: one outstanding I-cache read feeding a DEPTH-entry FIFO; head reaches decode the cycle after icache_resp.
// Fetch pauses while the FIFO is full; id_stall holds the head; redirect flushes and drops any in-flight response.
module inst_queue
  import rv32i_types::*;
#(
  parameter int unsigned  DEPTH    = 4,
  parameter logic [31:0]  RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        icache_read,
  output logic [31:0] icache_address,
  input  logic [31:0] icache_rdata,
  input  logic        icache_resp,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_u_imm,
  output logic        id_false_nop
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;

  logic          push, pop, full, empty;
  fetch_entry_t  push_data, head;
  logic [CW-1:0] count, cnt_after;

  assign push      = (state_q == REQ) && icache_resp && !redirect;
  assign pop       = !empty && !id_stall && !redirect;
  assign push_data = '{pc: req_addr_q, instr: icache_rdata};
  // Occupancy once this cycle's push lands; decides whether another read fits.
  assign cnt_after = count + CW'(1) - CW'(pop);

  inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .full      (full),
    .empty     (empty),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else if (!full) begin
          state_d    = REQ;
          req_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect) begin
          // The outstanding read must still complete; DISCARD swallows it.
          fetch_pc_d = redirect_pc;
          state_d    = icache_resp ? IDLE : DISCARD;
        end else if (icache_resp) begin
          fetch_pc_d = req_addr_q + 32'd4;
          if (cnt_after < CW'(DEPTH)) req_addr_d = req_addr_q + 32'd4;
          else                        state_d    = IDLE;
        end
      end
      DISCARD: begin
        if (redirect)    fetch_pc_d = redirect_pc;
        if (icache_resp) state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    icache_read    = (state_q != IDLE);
    icache_address = req_addr_q;
    if (empty || redirect) begin
      id_instr     = NOP_INSTR;
      id_pc        = fetch_pc_q;
      id_false_nop = 1'b1;
    end else begin
      id_instr     = head.instr;
      id_pc        = head.pc;
      id_false_nop = 1'b0;
    end
    id_u_imm = {id_instr[31:12], 12'b0};
  end
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: cycle table after reset plus stall, redirect, steady-state and reset sequences.
module tb_inst_queue;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_read;
  logic [31:0] icache_address;
  logic [31:0] icache_rdata;
  logic        icache_resp;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic [31:0] id_instr, id_pc, id_u_imm;
  logic        id_false_nop;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(4), .RESET_PC(32'h0000_0060)) dut (
    .clk            (clk),
    .rst            (rst),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .icache_rdata   (icache_rdata),
    .icache_resp    (icache_resp),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_u_imm       (id_u_imm),
    .id_false_nop   (id_false_nop)
  );

  int          errors = 0;
  int          checks = 0;
  bit          auto_en;
  int          lat;
  int          pend;
  logic [31:0] exp_pc;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_nop;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;
  vec_t vt [8];

  function automatic logic [31:0] dat_of(input logic [31:0] a);
    return {12'hABC, a[19:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, then check any instruction decode accepts.
  task automatic cycle(input logic stall, input logic redir, input logic [31:0] rpc,
                       input logic mresp, input logic [31:0] mdata);
    @(negedge clk);
    id_stall    = stall;
    redirect    = redir;
    redirect_pc = rpc;
    if (auto_en) begin
      icache_resp  = 1'b0;
      icache_rdata = 32'h0;
      if (icache_read) begin
        if (pend >= lat) begin
          icache_resp  = 1'b1;
          icache_rdata = dat_of(icache_address);
          pend = 0;
        end else begin
          pend++;
        end
      end
    end else begin
      icache_resp  = mresp;
      icache_rdata = mdata;
    end
    #1;
    if (!id_false_nop && !stall && !redir) begin
      chk("pop_pc", id_pc, exp_pc);
      chk("pop_instr", id_instr, dat_of(exp_pc));
      chk("pop_uimm", id_u_imm, {12'hABC, exp_pc[19:12], 12'h000});
      exp_pc = exp_pc + 32'd4;
    end
    if (redir) exp_pc = rpc;
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    auto_en = 1'b0;
    id_stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    icache_resp = 1'b0;
    icache_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read", icache_read, 0);
    chk("rst_nop", id_false_nop, 1);
    chk("rst_instr", id_instr, 32'h13);
    chk("rst_pc", id_pc, 32'h60);
    rst = 1'b0;
    pend = 0;
    exp_pc = 32'h60;
  endtask

  task automatic wait_addr(input string name, input logic [31:0] addr);
    int n = 0;
    do begin
      cycle(0, 0, 0, 0, 0);
      peek();
      n++;
    end while (!(icache_read && icache_address == addr) && n < 50);
    chk(name, (n < 50) ? 1 : 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    vt[0] = '{1'b0, 32'h0,         1'b0, 32'h60, 1'b1, 32'h60, 32'h13};
    vt[1] = '{1'b0, 32'h0,         1'b1, 32'h60, 1'b1, 32'h60, 32'h13};
    vt[2] = '{1'b1, 32'hABC0_0060, 1'b1, 32'h60, 1'b1, 32'h60, 32'h13};
    vt[3] = '{1'b0, 32'h0,         1'b1, 32'h64, 1'b0, 32'h60, 32'hABC0_0060};
    vt[4] = '{1'b1, 32'hABC0_0064, 1'b1, 32'h64, 1'b1, 32'h64, 32'h13};
    vt[5] = '{1'b0, 32'h0,         1'b1, 32'h68, 1'b0, 32'h64, 32'hABC0_0064};
    vt[6] = '{1'b1, 32'hABC0_0068, 1'b1, 32'h68, 1'b1, 32'h68, 32'h13};
    vt[7] = '{1'b0, 32'h0,         1'b1, 32'h6C, 1'b0, 32'h68, 32'hABC0_0068};

    // Fetch start-up with a cache answering one cycle after each read.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, vt[i].resp, vt[i].rdata);
      chk($sformatf("t%0d_read", i), icache_read, vt[i].e_read);
      chk($sformatf("t%0d_addr", i), icache_address, vt[i].e_addr);
      chk($sformatf("t%0d_nop", i), id_false_nop, vt[i].e_nop);
      chk($sformatf("t%0d_pc", i), id_pc, vt[i].e_pc);
      chk($sformatf("t%0d_instr", i), id_instr, vt[i].e_instr);
      chk($sformatf("t%0d_uimm", i), id_u_imm, {vt[i].e_instr[31:12], 12'h000});
    end

    // Decode stalled: queue fills to DEPTH and fetch stops.
    do_reset();
    auto_en = 1'b1; lat = 1;
    repeat (20) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("s1_full_read", icache_read, 0);
    chk("s1_full_nop", id_false_nop, 0);
    chk("s1_full_head", id_pc, 32'h60);
    cycle(0, 0, 0, 0, 0);
    chk("s1_r0_read", icache_read, 0);
    cycle(0, 0, 0, 0, 0);
    chk("s1_r1_read", icache_read, 0);
    cycle(0, 0, 0, 0, 0);
    chk("s1_r2_read", icache_read, 1);
    chk("s1_r2_addr", icache_address, 32'h70);
    repeat (12) cycle(0, 0, 0, 0, 0);
    chk("s1_progress", (exp_pc >= 32'h78) ? 1 : 0, 1);

    // Redirect while 0x70 is outstanding; its response arrives three cycles later.
    do_reset();
    auto_en = 1'b1; lat = 1;
    wait_addr("s2_wait70", 32'h70);
    auto_en = 1'b0;
    cycle(0, 1, 32'h200, 0, 0);
    chk("s2_redir_nop", id_false_nop, 1);
    for (int k = 0; k < 2; k++) begin
      cycle(0, 0, 0, 0, 0);
      chk("s2_disc_read", icache_read, 1);
      chk("s2_disc_addr", icache_address, 32'h70);
      chk("s2_disc_nop", id_false_nop, 1);
      chk("s2_disc_pc", id_pc, 32'h200);
    end
    cycle(0, 0, 0, 1, dat_of(32'h70));
    cycle(0, 0, 0, 0, 0);
    chk("s2_idle_read", icache_read, 0);
    chk("s2_idle_nop", id_false_nop, 1);
    chk("s2_idle_pc", id_pc, 32'h200);
    pend = 0; auto_en = 1'b1;
    cycle(0, 0, 0, 0, 0);
    chk("s2_req_read", icache_read, 1);
    chk("s2_req_addr", icache_address, 32'h200);
    repeat (6) cycle(0, 0, 0, 0, 0);
    chk("s2_refetch", (exp_pc >= 32'h204) ? 1 : 0, 1);

    // Redirect in the same cycle as a response.
    do_reset();
    auto_en = 1'b1; lat = 1;
    wait_addr("s3_wait68", 32'h68);
    auto_en = 1'b0;
    cycle(0, 1, 32'h300, 1, dat_of(32'h68));
    chk("s3_redir_nop", id_false_nop, 1);
    cycle(0, 0, 0, 0, 0);
    chk("s3_idle_read", icache_read, 0);
    chk("s3_idle_nop", id_false_nop, 1);
    chk("s3_idle_pc", id_pc, 32'h300);
    pend = 0; auto_en = 1'b1;
    cycle(0, 0, 0, 0, 0);
    chk("s3_req_read", icache_read, 1);
    chk("s3_req_addr", icache_address, 32'h300);
    repeat (6) cycle(0, 0, 0, 0, 0);
    chk("s3_refetch", (exp_pc >= 32'h304) ? 1 : 0, 1);

    // Steady push+pop at two entries across pointer wrap.
    do_reset();
    auto_en = 1'b1; lat = 0;
    repeat (3) cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 0, 0, 0);
      chk($sformatf("s4_c%0d_nop", k), id_false_nop, 0);
      chk($sformatf("s4_c%0d_read", k), icache_read, 1);
    end
    auto_en = 1'b0;
    cnt = 0;
    repeat (5) begin
      cycle(0, 0, 0, 0, 0);
      if (!id_false_nop) cnt++;
    end
    chk("s4_drain_count", cnt, 2);

    // Reset asserted in the middle of a request.
    do_reset();
    auto_en = 1'b1; lat = 2;
    wait_addr("s5_wait64", 32'h64);
    rst = 1'b1;
    #1;
    chk("s5_rst_read", icache_read, 0);
    chk("s5_rst_nop", id_false_nop, 1);
    chk("s5_rst_pc", id_pc, 32'h60);
    do_reset();
    auto_en = 1'b1; lat = 1;
    cycle(0, 0, 0, 0, 0);
    chk("s5_idle_read", icache_read, 0);
    chk("s5_idle_nop", id_false_nop, 1);
    cycle(0, 0, 0, 0, 0);
    chk("s5_req_read", icache_read, 1);
    chk("s5_req_addr", icache_address, 32'h60);
    repeat (6) cycle(0, 0, 0, 0, 0);
    chk("s5_refetch", (exp_pc >= 32'h64) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of queue entries; power of two, 2..16.
REQ-002 Parameter: RESET_PC, default 32'h0000_0060, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 icache_read  output  1  I-cache read request; held high until icache_resp.
REQ-006 icache_address  output  32  request address; stable while icache_read is high.
REQ-007 icache_rdata  input  32  returned instruction word; valid when icache_resp=1.
REQ-008 icache_resp  input  1  one-cycle completion pulse for the current request.
REQ-009 redirect  input  1  branch/jump taken in a later stage; flush and refetch.
REQ-010 redirect_pc  input  32  new fetch address; valid when redirect=1.
REQ-011 id_stall  input  1  decode cannot accept an instruction this cycle.
REQ-012 id_instr  output  32  instruction word presented to the decode stage (control_rom data input).
REQ-013 id_pc  output  32  PC of id_instr.
REQ-014 id_u_imm  output  32  {id_instr[31:12], 12'b0}.
REQ-015 id_false_nop  output  1  id_instr is an inserted bubble; decode produces no control.

Function
REQ-016 The block SHALL hold a fetch_pc, a req_addr, a DEPTH-entry FIFO of {pc, instr}, read/write pointers and a count of width $clog2(DEPTH)+1.
REQ-017 FSM states: IDLE (icache_read=0), REQ (icache_read=1, address=req_addr), DISCARD (icache_read=1, address=req_addr, response is dropped).
REQ-018 IDLE->REQ when count<DEPTH and redirect=0; req_addr<=fetch_pc.
REQ-019 REQ with icache_resp=1 and redirect=0: push {req_addr, icache_rdata}; fetch_pc<=req_addr+4; stay in REQ with req_addr<=req_addr+4 if post-push count<DEPTH, else go to IDLE.
REQ-020 REQ with redirect=1 and icache_resp=0: go to DISCARD; fetch_pc<=redirect_pc; req_addr is unchanged.
REQ-021 DISCARD with icache_resp=1: drop the data; go to IDLE. A redirect in DISCARD only updates fetch_pc.
REQ-022 Redirect with icache_resp=1 in the same cycle: drop the response; fetch_pc<=redirect_pc; go to IDLE.
REQ-023 Redirect SHALL empty the FIFO (count<=0, pointers<=0) in the same edge; a flush overrides a same-cycle push or pop.
REQ-024 A pop occurs when count>0, id_stall=0 and redirect=0. A push and a pop in the same cycle leave count unchanged.
REQ-025 id_instr/id_pc SHALL be the FIFO head, combinationally. When count=0 or redirect=1: id_instr=32'h0000_0013 (addi x0,x0,0), id_false_nop=1, id_pc=fetch_pc.
REQ-026 A push SHALL never occur into a full FIFO; a new request is issued only when count<DEPTH, so the in-flight response always fits.
REQ-027 Pointers wrap modulo DEPTH; fetch_pc+4 wraps modulo 2^32.
REQ-028 Latency: an instruction is visible on id_instr no earlier than the cycle after its icache_resp.

Reset
REQ-029 While rst=1: state=IDLE, fetch_pc=RESET_PC, req_addr=RESET_PC, count=0, pointers=0.
REQ-030 Outputs under reset: icache_read=0, id_false_nop=1, id_instr=32'h13, id_pc=RESET_PC.
REQ-031 Reset mid-request abandons the request immediately; the cache controller treats the dropped read as cancelled.

Structure
REQ-032 The NOP encoding and the RESET_PC default SHALL live in rv32i_types; the FSM state enum is local to the module.
REQ-033 The FIFO SHALL be a sub-module named inst_fifo (push, pop, flush, full, empty, head); the FSM and the PC logic stay in inst_queue.

Verification
REQ-034 Reset release, cache responding 1 cycle after each read -> requests to 0x60, 0x64, 0x68...; first id_instr is valid (id_false_nop=0) one cycle after the first resp.
REQ-035 id_stall held at 1 -> after 4 responses icache_read=0 and count=4; release id_stall -> one pop per cycle and fetching resumes.
REQ-036 Redirect to 0x200 while a read of 0x70 is pending, resp 3 cycles later -> the 0x70 data is never enqueued; the next request is 0x200.
REQ-037 Redirect in the same cycle as a resp -> data dropped, FIFO empty next cycle, id_false_nop=1, next address = redirect_pc.
REQ-038 Simultaneous push and pop at count=2 for 10 cycles -> count stays 2; PC order is monotonically +4 across pointer wrap.
REQ-039 Assert rst mid-REQ -> icache_read=0 immediately; after release, fetch restarts at 0x60 with an empty FIFO.
